// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : AHB-Lite encodings, slave FSM states and byte-lane helpers.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // size is hsize[1:0] of an already-validated transfer (0..2)
    function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] lanes;
        case (size)
            2'd0:    lanes = 4'b0001 << addr_lo;
            2'd1:    lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : ahb_byte_ram
// Brief    : DEPTH x 32 memory, byte-enable write port, combinational read.
// Revision : 1.0
// ============================================================================
module ahb_byte_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we[g]) begin
                r_mem[waddr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM slave with configurable wait states and ERROR response.
// Revision : 1.0
// ============================================================================
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] c_WAIT_LOAD = 2'(WAIT_STATES);

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_wcnt, w_wcnt_nxt;
    logic          r_pend;
    logic          r_write;
    logic [1:0]    r_size;
    logic [AW+1:0] r_addr;

    logic          w_ready;
    logic          w_accept;
    logic          w_err;
    logic          w_complete;
    logic [3:0]    w_we;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_unused = ^hburst;

    assign w_ready  = ~((r_state == ST_ERR1) || (r_state == ST_WAIT && r_wcnt != 2'd0));
    assign w_accept = hsel && hready && w_ready &&
                      (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    assign w_err = (32'(haddr[31:2]) >= 32'(DEPTH)) ||
                   (hsize > HSIZE_WORD) ||
                   (hsize == HSIZE_HALF && haddr[0]) ||
                   (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);

    // A pending OKAY transfer completes in the first cycle the slave is ready.
    assign w_complete = r_pend && w_ready && !rst;
    assign w_we       = {4{w_complete && r_write}} & byte_lanes(r_size, r_addr[1:0]);

    assign hreadyout = rst || w_ready;
    assign hresp     = !rst && (r_state == ST_ERR1 || r_state == ST_ERR2) ? c_HRESP_ERROR
                                                                          : c_HRESP_OKAY;
    assign hrdata    = (w_complete && !r_write) ? w_rdata : 32'h0;

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            ST_WAIT: begin
                if (r_wcnt != 2'd0) begin
                    w_wcnt_nxt = r_wcnt - 2'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_accept) begin
            if (w_err) begin
                w_state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                w_state_nxt = ST_WAIT;
                w_wcnt_nxt  = c_WAIT_LOAD;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 2'd0;
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_ready) begin
                r_pend <= w_accept && !w_err;
            end
            if (w_accept) begin
                r_addr  <= haddr[AW+1:0];
                r_write <= hwrite;
                r_size  <= hsize[1:0];
            end
        end
    end

    ahb_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_addr[AW+1:2]),
        .wdata (hwdata),
        .raddr (r_addr[AW+1:2]),
        .rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_slave
// Brief    : Directed self-checking bench, zero-wait and two-wait slave instances.
// Revision : 1.0
// ============================================================================
module tb_ahb_sram_slave;

    localparam logic [2:0] c_BYTE = 3'd0;
    localparam logic [2:0] c_HALF = 3'd1;
    localparam logic [2:0] c_WORD = 3'd2;
    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_NSEQ = 2'b10;

    logic        clk;
    logic        rst;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata2;
    logic        hreadyout0, hreadyout2;
    logic        hresp0, hresp2;

    int checks = 0;
    int errors = 0;

    ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready(hreadyout0), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
    );

    ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready(hreadyout2), .hrdata(hrdata2), .hreadyout(hreadyout2), .hresp(hresp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdy(input int which);
        return (which == 0) ? hreadyout0 : hreadyout2;
    endfunction

    function automatic logic rsp(input int which);
        return (which == 0) ? hresp0 : hresp2;
    endfunction

    function automatic logic [31:0] rdat(input int which);
        return (which == 0) ? hrdata0 : hrdata2;
    endfunction

    // Single non-pipelined transfer; reports what was seen in the data phase.
    task automatic xfer(input int which, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int low,
                        output logic resp_low, output logic resp_end, output logic leak);
        hsel0  = (which == 0);
        hsel2  = (which == 2);
        haddr  = a;
        htrans = c_NSEQ;
        hwrite = w;
        hsize  = sz;
        @(posedge clk); #1;
        hsel0    = 1'b0;
        hsel2    = 1'b0;
        htrans   = c_IDLE;
        hwdata   = wd;
        low      = 0;
        resp_low = 1'b0;
        resp_end = 1'b0;
        leak     = 1'b0;
        rd       = 'x;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdy(which)) begin
                rd       = rdat(which);
                resp_end = rsp(which);
                break;
            end
            low++;
            resp_low = resp_low | rsp(which);
            if (rdat(which) !== 32'h0) leak = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (hreadyout0 !== 1'b1 || hreadyout2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_hreadyout: got %b/%b expected 1/1", hreadyout0, hreadyout2);
        end
        checks++;
        if (hresp0 !== 1'b0 || hresp2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hresp: got %b/%b expected 0/0", hresp0, hresp2);
        end
        checks++;
        if (hrdata0 !== 32'h0 || hrdata2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_hrdata: got %h/%h expected 0/0", hrdata0, hrdata2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Write address phase overlaps the reset release edge's first cycle.
    task automatic test_basic;
        hsel0 = 1'b1; haddr = 32'h10; htrans = c_NSEQ; hwrite = 1'b1; hsize = c_WORD;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF;
        hwrite = 1'b0;
        @(negedge clk);
        checks++;
        if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0 || hrdata0 !== 32'h0) begin
            errors++;
            $display("FAIL basic_write_phase: got rdy=%b resp=%b rd=%h expected 1 0 0",
                     hreadyout0, hresp0, hrdata0);
        end
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = c_IDLE;
        @(negedge clk);
        checks++;
        if (hrdata0 !== 32'hDEADBEEF || hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_read: got rd=%h rdy=%b resp=%b expected deadbeef 1 0",
                     hrdata0, hreadyout0, hresp0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (hrdata0 !== 32'h0) begin
            errors++;
            $display("FAIL basic_idle_rdata: got %h expected 0", hrdata0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd;
        int          low;
        logic        rl, re, lk;
        xfer(0, 32'h10, 1'b1, c_WORD, 32'h11223344, rd, low, rl, re, lk);
        xfer(0, 32'h13, 1'b1, c_BYTE, 32'hAA000000, rd, low, rl, re, lk);
        xfer(0, 32'h10, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (rd !== 32'hAA223344) begin
            errors++;
            $display("FAIL byte_write: got %h expected aa223344", rd);
        end
        xfer(0, 32'h14, 1'b1, c_WORD, 32'h55667788, rd, low, rl, re, lk);
        xfer(0, 32'h16, 1'b1, c_HALF, 32'h12340000, rd, low, rl, re, lk);
        xfer(0, 32'h14, 1'b1, c_HALF, 32'h0000ABCD, rd, low, rl, re, lk);
        xfer(0, 32'h15, 1'b1, c_BYTE, 32'h0000EE00, rd, low, rl, re, lk);
        xfer(0, 32'h14, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (rd !== 32'h1234EECD) begin
            errors++;
            $display("FAIL half_byte_write: got %h expected 1234eecd", rd);
        end
    endtask

    task automatic test_wait;
        logic [31:0] rd;
        int          low;
        logic        rl, re, lk;
        xfer(2, 32'h0, 1'b1, c_WORD, 32'hCAFE0001, rd, low, rl, re, lk);
        checks++;
        if (low != 2 || re !== 1'b0) begin
            errors++;
            $display("FAIL wait_write: got low=%0d resp=%b expected 2 0", low, re);
        end
        xfer(2, 32'h0, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (low != 2) begin
            errors++;
            $display("FAIL wait_read_cycles: got %0d expected 2", low);
        end
        checks++;
        if (rd !== 32'hCAFE0001 || re !== 1'b0 || rl !== 1'b0 || lk !== 1'b0) begin
            errors++;
            $display("FAIL wait_read_data: got rd=%h resp=%b/%b leak=%b expected cafe0001 0/0 0",
                     rd, rl, re, lk);
        end
    endtask

    task automatic test_error;
        logic [31:0] rd;
        int          low;
        logic        rl, re, lk;
        xfer(0, 32'h0, 1'b1, c_WORD, 32'h01020304, rd, low, rl, re, lk);
        xfer(0, 32'h402, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (low != 1 || rl !== 1'b1 || re !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_unaligned_402: got low=%0d resp=%b/%b rd=%h expected 1 1/1 0",
                     low, rl, re, rd);
        end
        xfer(0, 32'h400, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (low != 1 || rl !== 1'b1 || re !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_range_400: got low=%0d resp=%b/%b rd=%h expected 1 1/1 0",
                     low, rl, re, rd);
        end
        xfer(0, 32'h10, 1'b0, 3'd3, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (low != 1 || rl !== 1'b1 || re !== 1'b1) begin
            errors++;
            $display("FAIL err_size: got low=%0d resp=%b/%b expected 1 1/1", low, rl, re);
        end
        xfer(0, 32'h400, 1'b1, c_WORD, 32'hFFFFFFFF, rd, low, rl, re, lk);
        xfer(0, 32'h12, 1'b1, c_WORD, 32'hFFFFFFFF, rd, low, rl, re, lk);
        xfer(0, 32'h11, 1'b1, c_HALF, 32'hFFFFFFFF, rd, low, rl, re, lk);
        checks++;
        if (low != 1 || re !== 1'b1) begin
            errors++;
            $display("FAIL err_half_unaligned: got low=%0d resp=%b expected 1 1", low, re);
        end
        xfer(0, 32'h0, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (rd !== 32'h01020304) begin
            errors++;
            $display("FAIL err_no_write_word0: got %h expected 01020304", rd);
        end
        xfer(0, 32'h10, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (rd !== 32'hAA223344 || re !== 1'b0) begin
            errors++;
            $display("FAIL err_no_write_word10: got %h resp=%b expected aa223344 0", rd, re);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        hsel0 = 1'b1; haddr = 32'h8; htrans = c_NSEQ; hwrite = 1'b1; hsize = c_WORD;
        @(posedge clk); #1;
        hwdata = 32'h5;
        hwrite = 1'b0;
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = c_IDLE;
        @(negedge clk);
        checks++;
        if (hrdata0 !== 32'h00000005 || hreadyout0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read: got rd=%h rdy=%b expected 00000005 1", hrdata0, hreadyout0);
        end
        @(posedge clk); #1;

        // Read address is held on the bus through the write's wait states.
        hsel2 = 1'b1; haddr = 32'h24; htrans = c_NSEQ; hwrite = 1'b1; hsize = c_WORD;
        @(posedge clk); #1;
        hwdata = 32'h00000077;
        hwrite = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (hreadyout2) break;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_wait_write: got %0d low cycles expected 2", n);
        end
        @(posedge clk); #1;
        hsel2 = 1'b0; htrans = c_IDLE;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (hreadyout2) break;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 2 || hrdata2 !== 32'h00000077) begin
            errors++;
            $display("FAIL b2b_wait_read: got low=%0d rd=%h expected 2 00000077", n, hrdata2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        int          low;
        logic        rl, re, lk;
        xfer(2, 32'h20, 1'b1, c_WORD, 32'h0BAD0BAD, rd, low, rl, re, lk);
        hsel2 = 1'b1; haddr = 32'h20; htrans = c_NSEQ; hwrite = 1'b1; hsize = c_WORD;
        @(posedge clk); #1;
        hsel2 = 1'b0; htrans = c_IDLE; hwdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (hreadyout2 !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait1: got hreadyout %b expected 0", hreadyout2);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (hreadyout2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== 32'h0) begin
            errors++;
            $display("FAIL abort_in_reset: got rdy=%b resp=%b rd=%h expected 1 0 0",
                     hreadyout2, hresp2, hrdata2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hreadyout2 !== 1'b1) begin
            errors++;
            $display("FAIL abort_after_reset: got hreadyout %b expected 1", hreadyout2);
        end
        @(posedge clk); #1;
        xfer(2, 32'h20, 1'b0, c_WORD, 32'h0, rd, low, rl, re, lk);
        checks++;
        if (rd !== 32'h0BAD0BAD || low != 2) begin
            errors++;
            $display("FAIL abort_old_value: got rd=%h low=%0d expected 0bad0bad 2", rd, low);
        end
    endtask

    initial begin
        rst    = 1'b1;
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        haddr  = 32'h0;
        htrans = c_IDLE;
        hwrite = 1'b0;
        hsize  = c_WORD;
        hburst = 3'd0;
        hwdata = 32'h0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait();
        test_error();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
